// File: rtl/dict_codec_engine.sv
// dict_codec_engine
// Responder for the compression memory interface. Keeps a dictionary of up
// to DEPTH unique DATA_W-bit words. COMPRESS returns a word's index and
// inserts the word on a miss. DECOMPRESS returns the word stored at an index.
// Each result is reported by a one-cycle pulse on response.
//
// Ports
//   clk              rising-edge clock
//   reset            asynchronous active-low reset
//   data_in          word to compress, sampled together with command
//   compressed_in    index to decompress, sampled together with command
//   command          00 NOP, 01 COMPRESS, 10 DECOMPRESS, 11 reserved
//   compressed_out   index result of COMPRESS (held until the next result)
//   decompressed_out word result of DECOMPRESS (held until the next result)
//   response         00 none/busy, 01 compress done, 10 decompress done, 11 error
//
// state  | meaning
// IDLE   | waiting for a command
// SEARCH | linear scan of the dictionary, one entry per cycle
// READ   | returning the word at the latched index
module dict_codec_engine #(
    parameter int DATA_W = 80,
    parameter int IDX_W  = 8,
    parameter int DEPTH  = 256
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic [IDX_W-1:0]  compressed_in,
    input  logic [1:0]        command,
    output logic [IDX_W-1:0]  compressed_out,
    output logic [DATA_W-1:0] decompressed_out,
    output logic [1:0]        response
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {IDLE, SEARCH, READ} state_t;

    state_t             state;
    logic [DATA_W-1:0]  dict [DEPTH];
    logic [CNT_W-1:0]   count;
    logic [CNT_W-1:0]   ptr;
    logic [DATA_W-1:0]  key;
    logic [IDX_W-1:0]   idx;
    logic               err_pend;

    logic hit;
    logic at_end;
    logic full;
    logic idx_valid;
    logic do_insert;

    // ptr never passes count, so "ptr < count" and "ptr == count" are the
    // only two cases the scan ever meets.
    assign hit       = (ptr < count) && (dict[AW'(ptr)] == key);
    assign at_end    = (ptr == count);
    assign full      = (count == CNT_W'(DEPTH));
    // Zero-extend both sides so the compare works whichever field is wider.
    assign idx_valid = ({{(32-IDX_W){1'b0}}, idx} < {{(32-CNT_W){1'b0}}, count});
    assign do_insert = (state == SEARCH) && !hit && at_end && !full;

    // The dictionary RAM is never reset. Entries at or above count are
    // treated as invalid, so a reset only has to clear count.
    always_ff @(posedge clk) begin
        if (do_insert) begin
            dict[AW'(count)] <= key;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= IDLE;
            count            <= '0;
            ptr              <= '0;
            key              <= '0;
            idx              <= '0;
            err_pend         <= 1'b0;
            compressed_out   <= '0;
            decompressed_out <= '0;
            response         <= 2'b00;
        end else begin
            response <= 2'b00;
            err_pend <= 1'b0;
            case (state)
                IDLE: begin
                    // A reserved command reports its error one edge after it
                    // is sampled. Commands that arrive in that gap are ignored.
                    if (err_pend) begin
                        response <= 2'b11;
                    end else begin
                        case (command)
                            2'b01: begin
                                key   <= data_in;
                                ptr   <= '0;
                                state <= SEARCH;
                            end
                            2'b10: begin
                                idx   <= compressed_in;
                                state <= READ;
                            end
                            2'b11:   err_pend <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                SEARCH: begin
                    if (hit) begin
                        compressed_out <= IDX_W'(ptr);
                        response       <= 2'b01;
                        state          <= IDLE;
                    end else if (at_end) begin
                        if (full) begin
                            compressed_out <= '0;
                            response       <= 2'b11;
                        end else begin
                            compressed_out <= IDX_W'(count);
                            response       <= 2'b01;
                            count          <= count + 1'b1;
                        end
                        state <= IDLE;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                READ: begin
                    if (idx_valid) begin
                        decompressed_out <= dict[AW'(idx)];
                        response         <= 2'b10;
                    end else begin
                        decompressed_out <= '0;
                        response         <= 2'b11;
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dict_codec_engine.sv
module tb_dict_codec_engine;

    logic        clk;
    logic        reset;
    logic [79:0] data_in;
    logic [7:0]  compressed_in;
    logic [1:0]  command;
    logic [7:0]  compressed_out;
    logic [79:0] decompressed_out;
    logic [1:0]  response;

    int tests = 0;
    int fails = 0;

    typedef struct {
        logic [1:0]  resp;
        logic [7:0]  cout;
        logic [79:0] dout;
        int          lat;
    } exp_t;

    typedef struct {
        logic [1:0]  cmd;
        logic [79:0] data;
        logic [7:0]  idx;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[14];

    dict_codec_engine dut (
        .clk              (clk),
        .reset            (reset),
        .data_in          (data_in),
        .compressed_in    (compressed_in),
        .command          (command),
        .compressed_out   (compressed_out),
        .decompressed_out (decompressed_out),
        .response         (response)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic exp_t mk(input logic [1:0] r, input logic [7:0] c,
                                input logic [79:0] d, input int l);
        exp_t e;
        e.resp = r;
        e.cout = c;
        e.dout = d;
        e.lat  = l;
        return e;
    endfunction

    function automatic vec_t mv(input logic [1:0] cmd, input logic [79:0] d,
                                input logic [7:0] ix, input exp_t e);
        vec_t v;
        v.cmd  = cmd;
        v.data = d;
        v.idx  = ix;
        v.e    = e;
        return v;
    endfunction

    task automatic check_idle_outputs(input string name, input logic [1:0] r,
                                      input logic [7:0] c, input logic [79:0] d);
        tests++;
        if (response !== r || compressed_out !== c || decompressed_out !== d) begin
            fails++;
            $display("FAIL %s: got resp=%b cout=%0d dout=%h, want resp=%b cout=%0d dout=%h",
                     name, response, compressed_out, decompressed_out, r, c, d);
        end
    endtask

    // Called at a negedge. The command is sampled at the next posedge (E0).
    task automatic run_cmd(input string name, input logic [1:0] cmd,
                           input logic [79:0] d, input logic [7:0] ix, input exp_t e);
        exp_t want;
        int   lat;
        bit   seen;
        sb.push_back(e);
        command       = cmd;
        data_in       = d;
        compressed_in = ix;
        @(negedge clk);
        command = 2'b00;
        tests++;
        if (response !== 2'b00) begin
            fails++;
            $display("FAIL %s pulse: response=%b at E0, want 00", name, response);
        end
        seen = 1'b0;
        lat  = 0;
        for (int n = 1; n <= 300 && !seen; n++) begin
            @(negedge clk);
            if (response !== 2'b00) begin
                seen = 1'b1;
                lat  = n;
            end
        end
        want = sb.pop_front();
        tests++;
        if (!seen) begin
            fails++;
            $display("FAIL %s: no response within 300 cycles, want resp=%b", name, want.resp);
        end else if (response !== want.resp || compressed_out !== want.cout ||
                     decompressed_out !== want.dout || lat != want.lat) begin
            fails++;
            $display("FAIL %s: got resp=%b cout=%0d dout=%h lat=%0d, want resp=%b cout=%0d dout=%h lat=%0d",
                     name, response, compressed_out, decompressed_out, lat,
                     want.resp, want.cout, want.dout, want.lat);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    localparam logic [79:0] W_A5  = 80'hA5A5_0000_0000_0000_1234;
    localparam logic [79:0] W_FF  = 80'hFFFF_FFFF_FFFF_FFFF_FFFF;
    localparam logic [79:0] W_NEW = 80'h0000_0000_0000_1234_5678;

    initial begin
        reset         = 1'b0;
        command       = 2'b00;
        data_in       = '0;
        compressed_in = '0;

        vecs[0]  = mv(2'b01, W_A5,  8'd0, mk(2'b01, 8'd0, 80'h0, 1));
        vecs[1]  = mv(2'b01, 80'h0, 8'd0, mk(2'b01, 8'd1, 80'h0, 2));
        vecs[2]  = mv(2'b01, 80'h0, 8'd0, mk(2'b01, 8'd1, 80'h0, 2));
        vecs[3]  = mv(2'b01, W_FF,  8'd0, mk(2'b01, 8'd2, 80'h0, 3));
        vecs[4]  = mv(2'b01, W_A5,  8'd0, mk(2'b01, 8'd0, 80'h0, 1));
        vecs[5]  = mv(2'b10, '0,    8'd1, mk(2'b10, 8'd0, 80'h0, 1));
        vecs[6]  = mv(2'b10, '0,    8'd2, mk(2'b10, 8'd0, W_FF, 1));
        vecs[7]  = mv(2'b10, '0,    8'd5, mk(2'b11, 8'd0, 80'h0, 1));
        vecs[8]  = mv(2'b10, '0,    8'd0, mk(2'b10, 8'd0, W_A5, 1));
        vecs[9]  = mv(2'b11, W_FF,  8'd7, mk(2'b11, 8'd0, W_A5, 1));
        vecs[10] = mv(2'b01, 80'h0, 8'd0, mk(2'b01, 8'd1, W_A5, 2));
        vecs[11] = mv(2'b01, W_NEW, 8'd0, mk(2'b01, 8'd3, W_A5, 4));
        vecs[12] = mv(2'b10, '0,    8'd3, mk(2'b10, 8'd3, W_NEW, 1));
        vecs[13] = mv(2'b10, '0,    8'd4, mk(2'b11, 8'd3, 80'h0, 1));

        repeat (3) @(negedge clk);
        check_idle_outputs("reset_state", 2'b00, 8'd0, 80'h0);
        reset = 1'b1;
        @(negedge clk);

        run_cmd("first_compress_zero", 2'b01, 80'h0, 8'd0, mk(2'b01, 8'd0, 80'h0, 1));
        do_reset();
        check_idle_outputs("after_reset", 2'b00, 8'd0, 80'h0);

        // Back-to-back directed table: each command is issued on the edge
        // right after the previous response.
        for (int i = 0; i < 14; i++) begin
            run_cmd($sformatf("vec%0d", i), vecs[i].cmd, vecs[i].data, vecs[i].idx, vecs[i].e);
        end

        // count is 4 here, so the fill runs from index 4 up to 255.
        for (int i = 4; i < 256; i++) begin
            run_cmd($sformatf("fill%0d", i), 2'b01, {16'hC0DE, 64'(i)}, 8'd0,
                    mk(2'b01, 8'(i), 80'h0, i + 1));
        end
        run_cmd("full_new_word", 2'b01, {16'hBEEF, 64'h0}, 8'd0, mk(2'b11, 8'd0, 80'h0, 257));
        run_cmd("hit_last", 2'b01, {16'hC0DE, 64'd255}, 8'd0, mk(2'b01, 8'd255, 80'h0, 256));
        run_cmd("read_last", 2'b10, '0, 8'd255, mk(2'b10, 8'd255, {16'hC0DE, 64'd255}, 1));
        run_cmd("read_200", 2'b10, '0, 8'd200, mk(2'b10, 8'd255, {16'hC0DE, 64'd200}, 1));

        // Reset two cycles into a long search. The hit would otherwise arrive
        // at E0+251, so no response may appear.
        command = 2'b01;
        data_in = {16'hC0DE, 64'd250};
        @(negedge clk);
        command = 2'b00;
        @(posedge clk);
        @(posedge clk);
        #1 reset = 1'b0;
        for (int n = 0; n < 3; n++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("mid_reset%0d", n), 2'b00, 8'd0, 80'h0);
        end
        reset = 1'b1;
        for (int n = 0; n < 4; n++) begin
            @(negedge clk);
            check_idle_outputs($sformatf("post_reset%0d", n), 2'b00, 8'd0, 80'h0);
        end
        run_cmd("read0_after_reset", 2'b10, '0, 8'd0, mk(2'b11, 8'd0, 80'h0, 1));
        run_cmd("compress_after_reset", 2'b01, 80'hABC, 8'd0, mk(2'b01, 8'd0, 80'h0, 1));
        run_cmd("read0_new", 2'b10, '0, 8'd0, mk(2'b10, 8'd0, 80'hABC, 1));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
